// File: rtl/mac_feed16_if.sv
// Load/stream bundle for mac_feed16.
// The slave modport is the producer block itself; the master modport is whoever
// feeds load beats and drains the product stream.
interface mac_feed16_if #(
    parameter int XW = 8,
    parameter int WW = 12,
    parameter int BW = 8
);
    localparam int DW = XW + WW;

    logic          ld_valid;
    logic          ld_ready;
    logic [XW-1:0] ld_x;
    logic [WW-1:0] ld_w;
    logic [BW-1:0] ld_b;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic [BW-1:0] b_out;
    logic          out_first;
    logic          out_last;

    modport slave (
        input  ld_valid, ld_x, ld_w, ld_b, out_ready,
        output ld_ready, out_valid, dout, b_out, out_first, out_last
    );

    modport master (
        output ld_valid, ld_x, ld_w, ld_b, out_ready,
        input  ld_ready, out_valid, dout, b_out, out_first, out_last
    );
endinterface

// File: rtl/mac_feed16.sv
// mac_feed16: buffers one neuron frame (N activation/weight pairs + bias) and
// streams the N signed products to the accumulator, framed by first/last.
// Build option: define MAC_FEED_DBUF_EN for two ping-pong banks so the next
// frame loads while the current one streams; undefined gives a single bank.
//
// Stream FSM:
//   state     | meaning
//   ST_LOAD   | output register empty (out_valid=0), waiting for a full bank
//   ST_STREAM | output register holds a valid product beat
//
// Banks are tracked by three pointers: lb (bank being loaded), ib (bank whose
// next beat goes into the output register) and sb (bank of the beat currently
// in the output register). A bank stays "full" until its last beat handshakes,
// which is what throttles ld_ready. In single-bank builds all pointers stay 0.
module mac_feed16 #(
    parameter int N  = 16,
    parameter int XW = 8,
    parameter int WW = 12,
    parameter int BW = 8
) (
    input  logic        clk,
    input  logic        rst,
    mac_feed16_if.slave bus
);
    localparam int DW = XW + WW;
    localparam int CW = $clog2(N);
`ifdef MAC_FEED_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    typedef enum logic {ST_LOAD, ST_STREAM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          lb_q, lb_d, ib_q, ib_d, sb_q, sb_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    rdy_q, rdy_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [BW-1:0] bout_q, bout_d;
    logic          first_q, first_d, last_q, last_d;

    logic [XW-1:0] mem_x_q [2][N];
    logic [WW-1:0] mem_w_q [2][N];
    logic [BW-1:0] bias_q  [2];

    logic          ld_fire, ld_done, out_fire, last_fire, adv;
    logic          issue_ok, issue, issue_last;
    logic [XW-1:0] rd_x;
    logic [WW-1:0] rd_w;
    logic [DW-1:0] prod;

    assign bus.ld_ready = ~full_q[lb_q];
    assign ld_fire      = bus.ld_valid & ~full_q[lb_q];
    assign ld_done      = ld_fire & (lcnt_q == CW'(N - 1));
    assign out_fire     = (state_q == ST_STREAM) & bus.out_ready;
    assign last_fire    = out_fire & last_q;
    assign adv          = (state_q != ST_STREAM) | bus.out_ready;
    // A bank completing this very cycle may feed the output register at once;
    // its beat 0 was written on an earlier edge.
    assign issue_ok     = rdy_q[ib_q] | (ld_done & (lb_q == ib_q));
    assign issue        = adv & issue_ok;
    assign issue_last   = issue & (scnt_q == CW'(N - 1));

    assign rd_x = mem_x_q[ib_q][scnt_q];
    assign rd_w = mem_w_q[ib_q][scnt_q];
    // Both operands sign-extended to DW; the full product always fits in DW bits.
    assign prod = {{WW{rd_x[XW-1]}}, rd_x} * {{XW{rd_w[WW-1]}}, rd_w};

    // Buffer RAM and per-bank bias: written on accepted load beats, never cleared.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem_x_q[lb_q][lcnt_q] <= bus.ld_x;
            mem_w_q[lb_q][lcnt_q] <= bus.ld_w;
            if (lcnt_q == '0) begin
                bias_q[lb_q] <= bus.ld_b;
            end
        end
    end

    // Next-state: load/stream counters, bank bookkeeping and output register.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        scnt_d  = scnt_q;
        lb_d    = lb_q;
        ib_d    = ib_q;
        sb_d    = sb_q;
        full_d  = full_q;
        rdy_d   = rdy_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        first_d = first_q;
        last_d  = last_q;

        if (ld_fire) begin
            lcnt_d = lcnt_q + 1'b1;
        end
        if (ld_done) begin
            full_d[lb_q] = 1'b1;
            rdy_d[lb_q]  = 1'b1;
            lb_d         = lb_q ^ DBUF;
        end
        if (last_fire) begin
            full_d[sb_q] = 1'b0;
            sb_d         = sb_q ^ DBUF;
        end
        if (issue) begin
            state_d = ST_STREAM;
            scnt_d  = scnt_q + 1'b1;
            dout_d  = prod;
            bout_d  = bias_q[ib_q];
            first_d = (scnt_q == '0);
            last_d  = (scnt_q == CW'(N - 1));
        end else if (adv) begin
            state_d = ST_LOAD;
        end
        if (issue_last) begin
            rdy_d[ib_q] = 1'b0;
            ib_d        = ib_q ^ DBUF;
        end
    end

    // State register with asynchronous reset; a reset discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            lcnt_q  <= '0;
            scnt_q  <= '0;
            lb_q    <= 1'b0;
            ib_q    <= 1'b0;
            sb_q    <= 1'b0;
            full_q  <= '0;
            rdy_q   <= '0;
            dout_q  <= '0;
            bout_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            scnt_q  <= scnt_d;
            lb_q    <= lb_d;
            ib_q    <= ib_d;
            sb_q    <= sb_d;
            full_q  <= full_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign bus.out_valid = (state_q == ST_STREAM);
    assign bus.dout      = dout_q;
    assign bus.b_out     = bout_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
endmodule
